vram_arbiter: RTL and testbench

Two-requester arbiter and burst sequencer in front of the single 256-bit vector RAM port (vram_r_* / vram_w_*).
- Requester 0 is the vector load/store unit; requester 1 is the vector DMA/debug master.
- Grants one transaction at a time, round-robin between requesters.
- Expands read bursts into consecutive 32-byte beats.
- Returns responses through a one-deep registered response slot with backpressure.

---
 rtl/vram_arbiter_if.sv | 29 ++
 rtl/vram_arbiter.sv | 145 ++++++++++++++
 tb/tb_vram_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Request/response channel between one requester and the vram arbiter.
// master = requester side, slave = arbiter side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_last;

  modport master (
    output req_valid, req_wen, req_addr, req_len, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_last
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_len, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_last
  );
endinterface

// File: rtl/vram_arbiter.sv
// Round-robin two-requester arbiter and read-burst sequencer for the vector RAM port.
// Accept at T, RAM beat at T+1, response at T+2; a held response slot stalls all RAM access.
module vram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  vram_arbiter_if.slave     m0,
  vram_arbiter_if.slave     m1,
  output logic              vram_r_ena,
  output logic [ADDR_W-1:0] vram_r_addr,
  input  logic [DATA_W-1:0] vram_r_data,
  output logic              vram_w_ena,
  output logic [ADDR_W-1:0] vram_w_addr,
  output logic [DATA_W-1:0] vram_w_data,
  output logic [DATA_W-1:0] vram_w_mask
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              grant_id;
  logic              accept;
  logic              issue;
  logic              slot_drain;

  logic              cur_id;
  logic              cur_wen;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] cur_wmask;
  logic [LEN_W-1:0]  remaining;

  logic              slot_valid;
  logic              slot_id;
  logic              slot_last;
  logic [DATA_W-1:0] slot_data;

  logic              sel_wen;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] sel_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    issue         = 1'b0;
    // The requester that did not win last time takes a tie.
    if (m0.req_valid && m1.req_valid) grant_id = ~last_grant;
    else                              grant_id = ~m0.req_valid;
    slot_drain    = slot_valid && (slot_id ? m1.resp_ready : m0.resp_ready);

    case (state)
      IDLE: begin
        // Ready is combinational, so it must be masked while reset is asserted.
        if (!rst && (m0.req_valid || m1.req_valid)) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!slot_valid || slot_drain) begin
          issue = 1'b1;
          if (remaining == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    m0.req_ready = accept && !grant_id;
    m1.req_ready = accept &&  grant_id;
    vram_r_ena   = issue && !cur_wen;
    vram_w_ena   = issue &&  cur_wen;
  end

  assign sel_wen   = grant_id ? m1.req_wen   : m0.req_wen;
  assign sel_addr  = grant_id ? m1.req_addr  : m0.req_addr;
  assign sel_len   = grant_id ? m1.req_len   : m0.req_len;
  assign sel_wdata = grant_id ? m1.req_wdata : m0.req_wdata;
  assign sel_wmask = grant_id ? m1.req_wmask : m0.req_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cur_wen    <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cur_wmask  <= '0;
      remaining  <= '0;
    end else if (accept) begin
      last_grant <= grant_id;
      cur_id     <= grant_id;
      cur_wen    <= sel_wen;
      cur_addr   <= sel_addr;
      cur_wdata  <= sel_wdata;
      cur_wmask  <= sel_wmask;
      remaining  <= sel_wen ? '0 : sel_len;
    end else if (issue) begin
      cur_addr   <= cur_addr + STRIDE;
      remaining  <= remaining - 1'b1;
    end
  end

  // Response slot: loads on every issued beat, clears only when its owner drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_id    <= 1'b0;
      slot_last  <= 1'b0;
      slot_data  <= '0;
    end else if (issue) begin
      slot_valid <= 1'b1;
      slot_id    <= cur_id;
      slot_last  <= (remaining == '0);
      slot_data  <= cur_wen ? '0 : vram_r_data;
    end else if (slot_drain) begin
      slot_valid <= 1'b0;
    end
  end

  assign m0.resp_valid = slot_valid && !slot_id;
  assign m1.resp_valid = slot_valid &&  slot_id;
  assign m0.resp_rdata = slot_data;
  assign m1.resp_rdata = slot_data;
  assign m0.resp_last  = slot_last;
  assign m1.resp_last  = slot_last;

  assign vram_r_addr = cur_addr;
  assign vram_w_addr = cur_addr;
  assign vram_w_data = cur_wdata;
  assign vram_w_mask = cur_wmask;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand-timed corner sequences, and a
// randomized run scored against a transaction-level model of the arbiter.
module tb_vram_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) m0_if ();
  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) m1_if ();

  logic          req_valid  [2];
  logic          req_wen    [2];
  logic [AW-1:0] req_addr   [2];
  logic [LW-1:0] req_len    [2];
  logic [DW-1:0] req_wdata  [2];
  logic [DW-1:0] req_wmask  [2];
  logic          resp_ready [2];
  logic          req_ready  [2];
  logic          resp_valid [2];
  logic          resp_last  [2];
  logic [DW-1:0] resp_rdata [2];

  assign m0_if.req_valid  = req_valid[0];
  assign m0_if.req_wen    = req_wen[0];
  assign m0_if.req_addr   = req_addr[0];
  assign m0_if.req_len    = req_len[0];
  assign m0_if.req_wdata  = req_wdata[0];
  assign m0_if.req_wmask  = req_wmask[0];
  assign m0_if.resp_ready = resp_ready[0];
  assign m1_if.req_valid  = req_valid[1];
  assign m1_if.req_wen    = req_wen[1];
  assign m1_if.req_addr   = req_addr[1];
  assign m1_if.req_len    = req_len[1];
  assign m1_if.req_wdata  = req_wdata[1];
  assign m1_if.req_wmask  = req_wmask[1];
  assign m1_if.resp_ready = resp_ready[1];
  assign req_ready[0]  = m0_if.req_ready;
  assign req_ready[1]  = m1_if.req_ready;
  assign resp_valid[0] = m0_if.resp_valid;
  assign resp_valid[1] = m1_if.resp_valid;
  assign resp_last[0]  = m0_if.resp_last;
  assign resp_last[1]  = m1_if.resp_last;
  assign resp_rdata[0] = m0_if.resp_rdata;
  assign resp_rdata[1] = m1_if.resp_rdata;

  logic          vram_r_ena, vram_w_ena;
  logic [AW-1:0] vram_r_addr, vram_w_addr;
  logic [DW-1:0] vram_r_data, vram_w_data, vram_w_mask;

  // RAM contents are a fixed function of the byte address.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    pat = {a, ~a, a ^ 32'h1234_5678, a + 32'd1, {a[15:0], a[31:16]},
           a ^ 32'hDEAD_BEEF, a * 32'd3, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  assign vram_r_data = pat(vram_r_addr);

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .vram_r_ena(vram_r_ena), .vram_r_addr(vram_r_addr), .vram_r_data(vram_r_data),
    .vram_w_ena(vram_w_ena), .vram_w_addr(vram_w_addr), .vram_w_data(vram_w_data),
    .vram_w_mask(vram_w_mask)
  );

  int   total = 0;
  int   bad   = 0;
  logic tb_last = 1'b1;

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s: got %b want %b", nm, a, e); end
  endtask

  task automatic chk32(input string nm, input logic [AW-1:0] a, input logic [AW-1:0] e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s: got %h want %h", nm, a, e); end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s: got %h want %h", nm, a, e); end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_rdy0"}, req_ready[0], 1'b0);
    chk1({tag, "_rdy1"}, req_ready[1], 1'b0);
    chk1({tag, "_rv0"}, resp_valid[0], 1'b0);
    chk1({tag, "_rv1"}, resp_valid[1], 1'b0);
    chk1({tag, "_rena"}, vram_r_ena, 1'b0);
    chk1({tag, "_wena"}, vram_w_ena, 1'b0);
    chk32({tag, "_raddr"}, vram_r_addr, 32'h0);
    chk32({tag, "_waddr"}, vram_w_addr, 32'h0);
    chkw({tag, "_wdata"}, vram_w_data, '0);
    chkw({tag, "_wmask"}, vram_w_mask, '0);
    chkw({tag, "_rdata"}, resp_rdata[0], '0);
  endtask

  task automatic quiesce();
    tick();
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    resp_ready[0] = 1'b1; resp_ready[1] = 1'b1;
    repeat (12) tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int            m;
    logic          wen;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    int            beats;
    logic [AW-1:0] last_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int            o;
    logic [AW-1:0] a;
    o = 1 - v.m;
    tick();
    req_valid[v.m] = 1'b1; req_wen[v.m] = v.wen; req_addr[v.m] = v.addr;
    req_len[v.m] = v.len; req_wdata[v.m] = v.wdata; req_wmask[v.m] = v.wmask;
    resp_ready[v.m] = 1'b1;
    settle();
    for (int c = 0; c < 20 && !req_ready[v.m]; c++) begin tick(); settle(); end
    chk1("vec_ready", req_ready[v.m], 1'b1);
    chk1("vec_other_ready", req_ready[o], 1'b0);
    tb_last = (v.m == 1);
    tick(); req_valid[v.m] = 1'b0; settle();
    for (int c = 1; c <= v.beats + 1; c++) begin
      if (c <= v.beats) begin
        a = v.addr + 32'(32 * (c - 1));
        chk1("vec_rena", vram_r_ena, !v.wen);
        chk1("vec_wena", vram_w_ena, v.wen);
        if (v.wen) begin
          chk32("vec_waddr", vram_w_addr, a);
          chkw("vec_wdata", vram_w_data, v.wdata);
          chkw("vec_wmask", vram_w_mask, v.wmask);
        end else begin
          chk32("vec_raddr", vram_r_addr, a);
        end
        if (c == v.beats) chk32("vec_last_addr", a, v.last_addr);
      end else begin
        chk1("vec_no_access", vram_r_ena || vram_w_ena, 1'b0);
      end
      if (c >= 2) begin
        a = v.addr + 32'(32 * (c - 2));
        chk1("vec_resp_valid", resp_valid[v.m], 1'b1);
        chkw("vec_rdata", resp_rdata[v.m], v.wen ? '0 : pat(a));
        chk1("vec_last", resp_last[v.m], c == v.beats + 1);
      end else begin
        chk1("vec_resp_early", resp_valid[v.m], 1'b0);
      end
      chk1("vec_other_resp", resp_valid[o], 1'b0);
      tick(); settle();
    end
  endtask

  // ---------------- randomized run with transaction model ----------------
  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } acc_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q0[$];
  rsp_t rsp_q1[$];
  bit   taken[2];

  task automatic model_accept(input int m);
    int   beats;
    acc_t e;
    rsp_t r;
    beats = req_wen[m] ? 1 : int'(req_len[m]) + 1;
    for (int k = 0; k < beats; k++) begin
      e.wen  = req_wen[m];
      e.addr = req_addr[m] + 32'(32 * k);
      e.data = req_wdata[m];
      e.mask = req_wmask[m];
      acc_q.push_back(e);
      r.data = req_wen[m] ? '0 : pat(e.addr);
      r.last = (k == beats - 1);
      if (m == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
    end
  endtask

  task automatic monitor_cycle();
    acc_t e;
    rsp_t r;
    logic exp_g;
    logic held;
    if (vram_r_ena || vram_w_ena) begin
      chk1("rw_exclusive", vram_r_ena && vram_w_ena, 1'b0);
      held = (resp_valid[0] && !resp_ready[0]) || (resp_valid[1] && !resp_ready[1]);
      chk1("access_while_stalled", held, 1'b0);
      if (acc_q.size() == 0) begin
        chk1("access_expected", 1'b0, 1'b1);
      end else begin
        e = acc_q.pop_front();
        chk1("acc_wen", vram_w_ena, e.wen);
        chk32("acc_addr", vram_w_ena ? vram_w_addr : vram_r_addr, e.addr);
        if (e.wen) begin
          chkw("acc_wdata", vram_w_data, e.data);
          chkw("acc_wmask", vram_w_mask, e.mask);
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (resp_valid[m] && resp_ready[m]) begin
        if ((m == 0 ? rsp_q0.size() : rsp_q1.size()) == 0) begin
          chk1("resp_expected", 1'b0, 1'b1);
        end else begin
          r = (m == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
          chkw("rsp_data", resp_rdata[m], r.data);
          chk1("rsp_last", resp_last[m], r.last);
        end
      end
    end
    if (resp_valid[0] || resp_valid[1])
      chk1("single_resp", resp_valid[0] && resp_valid[1], 1'b0);
    for (int m = 0; m < 2; m++) begin
      if (req_ready[m]) begin
        chk1("ready_needs_valid", req_valid[m], 1'b1);
        chk1("single_grant", req_ready[1 - m], 1'b0);
        exp_g = (req_valid[0] && req_valid[1]) ? !tb_last : !req_valid[0];
        chk1("grant_rr", m == 1, exp_g);
        model_accept(m);
        tb_last  = (m == 1);
        taken[m] = 1'b1;
      end
    end
  endtask

  task automatic rand_phase(input int ncyc, input bit gen);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (taken[m]) begin req_valid[m] = 1'b0; taken[m] = 1'b0; end
        if (gen) begin
          if (!req_valid[m] && $urandom_range(0, 3) == 0) begin
            req_valid[m] = 1'b1;
            req_wen[m]   = ($urandom_range(0, 3) == 0);
            req_addr[m]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63))
                                                      : 32'($urandom);
            req_len[m]   = LW'($urandom_range(0, 7));
            for (int w = 0; w < 8; w++) begin
              req_wdata[m][w*32 +: 32] = 32'($urandom);
              req_wmask[m][w*32 +: 32] = 32'($urandom);
            end
          end
          resp_ready[m] = ($urandom_range(0, 3) != 0);
        end else begin
          req_valid[m]  = 1'b0;
          resp_ready[m] = 1'b1;
        end
      end
      settle();
      monitor_cycle();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      req_valid[m] = 1'b0; req_wen[m] = 1'b0; req_addr[m] = '0; req_len[m] = '0;
      req_wdata[m] = '0; req_wmask[m] = '0; resp_ready[m] = 1'b1; taken[m] = 1'b0;
    end

    vecs[0] = '{0, 1'b0, 32'h0000_0100, 3'd0, '0, '0, 1, 32'h0000_0100};
    vecs[1] = '{1, 1'b0, 32'h0000_1000, 3'd3, '0, '0, 4, 32'h0000_1060};
    vecs[2] = '{0, 1'b1, 32'h0000_0040, 3'd5, {8{32'hD00D_F00D}}, '1, 1, 32'h0000_0040};
    vecs[3] = '{1, 1'b0, 32'hFFFF_FFE0, 3'd1, '0, '0, 2, 32'h0000_0000};
    vecs[4] = '{0, 1'b1, 32'h0000_0007, 3'd0, {8{32'h1357_9BDF}}, {8{32'h0000_FFFF}}, 1, 32'h0000_0007};
    vecs[5] = '{1, 1'b0, 32'h0000_0013, 3'd2, '0, '0, 3, 32'h0000_0053};

    // Reset: outputs zero even with a request presented.
    tick();
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0100;
    settle();
    check_all_zero("reset");
    tick();
    rst = 1'b0; req_valid[0] = 1'b0;
    settle();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both requesters always valid: grants must alternate.
    quiesce();
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      tick();
      if (c == 0) begin
        for (int m = 0; m < 2; m++) begin
          req_valid[m] = 1'b1; req_wen[m] = 1'b0; req_len[m] = '0;
          req_addr[m] = (m == 0) ? 32'h0000_0200 : 32'h0000_0300;
        end
      end
      settle();
      for (int m = 0; m < 2; m++) begin
        if (req_ready[m]) begin
          chk1("alt_grant", m == 1, !tb_last);
          tb_last = (m == 1);
          n++;
        end
      end
    end
    total++;
    if (n != 6) begin bad++; $display("FAIL alt_count: got %0d want 6", n); end

    // Stall with the slot full, across the top-of-memory wrap.
    quiesce();
    tick();
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'hFFFF_FFE0; req_len[0] = 3'd2;
    settle();
    chk1("st_ready", req_ready[0], 1'b1);
    tb_last = 1'b0;
    tick(); req_valid[0] = 1'b0; settle();
    chk1("st_b0_rena", vram_r_ena, 1'b1);
    chk32("st_b0_addr", vram_r_addr, 32'hFFFF_FFE0);
    tick(); resp_ready[0] = 1'b0; settle();
    chk1("st_b0_valid", resp_valid[0], 1'b1);
    chkw("st_b0_data", resp_rdata[0], pat(32'hFFFF_FFE0));
    chk1("st_b0_last", resp_last[0], 1'b0);
    chk1("st_hold_rena0", vram_r_ena, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick(); settle();
      chk1("st_hold_rena", vram_r_ena, 1'b0);
      chk1("st_hold_valid", resp_valid[0], 1'b1);
      chkw("st_hold_data", resp_rdata[0], pat(32'hFFFF_FFE0));
    end
    tick(); resp_ready[0] = 1'b1; settle();
    chk1("st_b1_rena", vram_r_ena, 1'b1);
    chk32("st_b1_addr", vram_r_addr, 32'h0000_0000);
    tick(); settle();
    chkw("st_b1_data", resp_rdata[0], pat(32'h0000_0000));
    chk1("st_b1_last", resp_last[0], 1'b0);
    chk1("st_b2_rena", vram_r_ena, 1'b1);
    chk32("st_b2_addr", vram_r_addr, 32'h0000_0020);
    tick(); settle();
    chk1("st_b2_valid", resp_valid[0], 1'b1);
    chkw("st_b2_data", resp_rdata[0], pat(32'h0000_0020));
    chk1("st_b2_last", resp_last[0], 1'b1);
    chk1("st_end_rena", vram_r_ena, 1'b0);
    tick(); settle();
    chk1("st_drained", resp_valid[0], 1'b0);

    // Randomized traffic, then drain and confirm nothing is outstanding.
    quiesce();
    rand_phase(2500, 1'b1);
    rand_phase(60, 1'b0);
    chk32("rand_acc_left", 32'(acc_q.size()), 32'h0);
    chk32("rand_rsp0_left", 32'(rsp_q0.size()), 32'h0);
    chk32("rand_rsp1_left", 32'(rsp_q1.size()), 32'h0);

    // Reset in the middle of an 8-beat burst.
    quiesce();
    tick();
    req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = 32'h0000_2000; req_len[1] = 3'd7;
    settle();
    chk1("mr_ready", req_ready[1], 1'b1);
    tick(); req_valid[1] = 1'b0; settle();
    tick(); settle();
    chk1("mr_busy", vram_r_ena, 1'b1);
    tick();
    rst = 1'b1;
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h0000_0500; req_len[0] = '0;
    req_valid[1] = 1'b1;
    settle();
    check_all_zero("midrst");
    tick(); tick();
    rst = 1'b0;
    tb_last = 1'b1;
    settle();
    chk1("post_rst_m0", req_ready[0], 1'b1);
    chk1("post_rst_m1", req_ready[1], 1'b0);
    chk1("post_rst_no_access", vram_r_ena, 1'b0);
    tick(); req_valid[0] = 1'b0; req_valid[1] = 1'b0; settle();
    chk1("post_rst_rena", vram_r_ena, 1'b1);
    chk32("post_rst_addr", vram_r_addr, 32'h0000_0500);
    quiesce();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
